// File: rtl/serial_frame_shifter_pkg.sv
// Shared types and helpers for the serial frame shifter and the
// bit-serial detector benches that it feeds.
// Optional feature macro: SER_PARITY_EN (appends an even-parity bit to each frame).
package ser_pkg;

  // Two-state frame controller: waiting for a word, or streaming one out.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Level held on the serial line between frames; the detector benches
  // assume the same resting level.
  localparam logic SER_IDLE_LEVEL = 1'b0;

  // Counter width large enough to hold every frame position 0..frame_len-1
  // with headroom for the frame length itself.
  function automatic int ser_cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/serial_frame_shifter_if.sv
// Parallel-word valid/ready handshake into the serial frame shifter.
// The master (source) drives the word and its valid; the slave (shifter)
// answers with ready.
interface serial_frame_shifter_if
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/serial_frame_shifter_bit_counter.sv
// Frame position counter for the serial frame shifter. Clears to zero on
// request, advances by one when enabled, and flags the final frame position.
// It saturates at FRAME_LEN-1 so it can never run past the end of a frame.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = ser_cnt_width(FRAME_LEN)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] r_count;

  // Position register: clear wins over increment, and increment stops at the last position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LAST_POS)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LAST_POS);

endmodule

// File: rtl/serial_frame_shifter.sv
// Serial frame shifter: accepts parallel words over a valid/ready handshake
// and streams them out one bit per clock, with ser_valid marking payload bits.
// A word offered on the final bit of a frame is taken immediately, so
// back-to-back words form a gapless stream.
// Optional feature macro: SER_PARITY_EN -- each frame gains a trailing
// even-parity bit computed when the word is captured.
module serial_frame_shifter
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic                    clk,
  input  logic                    reset_n,
  serial_frame_shifter_if.slave   s_if,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  ser_state_t       r_state;
  ser_state_t       w_next_state;
  logic [WIDTH-1:0] r_sreg;
  logic             w_accept;
  logic             w_tc;
  logic             w_clear;
  logic             w_inc;
  logic             w_data_bit;
`ifdef SER_PARITY_EN
  logic             r_parity;
`endif

  // in_ready is decoded from registered state only, so accept has no
  // combinational loop back through the source's valid.
  assign w_accept   = s_if.in_valid && s_if.in_ready;
  assign w_clear    = w_accept || ((r_state == ST_SHIFT) && w_tc);
  assign w_inc      = (r_state == ST_SHIFT) && !w_tc;
  assign w_data_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

  ser_bit_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_tc    (w_tc)
  );

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: stay in SHIFT until the last bit, unless a new word is taken there.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next_state = (!w_tc || w_accept) ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Shift register load/shift; vacated positions fill with zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sreg <= '0;
    end else if (w_accept) begin
      r_sreg <= s_if.in_data;
    end else if (r_state == ST_SHIFT) begin
      r_sreg <= MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
    end
  end

`ifdef SER_PARITY_EN
  // Parity of the word, captured alongside it so later shifting cannot disturb it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^s_if.in_data;
    end
  end
`endif

  // Output decode from state, shift register and terminal-count flag.
  always_comb begin
    s_if.in_ready = 1'b1;
    ser_valid     = 1'b0;
    busy          = 1'b0;
    ser_out       = IDLE_LEVEL;
    case (r_state)
      ST_IDLE: begin
        s_if.in_ready = 1'b1;
      end
      ST_SHIFT: begin
        s_if.in_ready = w_tc;
        ser_valid     = 1'b1;
        busy          = 1'b1;
`ifdef SER_PARITY_EN
        ser_out       = w_tc ? r_parity : w_data_bit;
`else
        ser_out       = w_data_bit;
`endif
      end
      default: begin
        s_if.in_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Bench for serial_frame_shifter. Three instances share clock and reset:
// 8-bit MSB-first, 8-bit LSB-first, and 2-bit MSB-first.
// Follows SER_PARITY_EN so the same vectors cover the parity build.
module tb_serial_frame_shifter;
  import ser_pkg::*;

`ifdef SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  serial_frame_shifter_if #(.WIDTH(8)) ifM ();
  serial_frame_shifter_if #(.WIDTH(8)) ifL ();
  serial_frame_shifter_if #(.WIDTH(2)) ifW ();

  logic serOutM, serValidM, busyM;
  logic serOutL, serValidL, busyL;
  logic serOutW, serValidW, busyW;

  serial_frame_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(SER_IDLE_LEVEL)) dutM (
    .clk(clk), .reset_n(reset_n), .s_if(ifM),
    .ser_out(serOutM), .ser_valid(serValidM), .busy(busyM)
  );

  serial_frame_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(SER_IDLE_LEVEL)) dutL (
    .clk(clk), .reset_n(reset_n), .s_if(ifL),
    .ser_out(serOutL), .ser_valid(serValidL), .busy(busyL)
  );

  serial_frame_shifter #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(SER_IDLE_LEVEL)) dutW (
    .clk(clk), .reset_n(reset_n), .s_if(ifW),
    .ser_out(serOutW), .ser_valid(serValidW), .busy(busyW)
  );

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] expStream;
    logic       expParity;
    int         nBits;
    bit         stall;
    string      name;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   passes = 0;
  int   sel    = 0;

  function automatic logic curOut();
    case (sel)
      0:       return serOutM;
      1:       return serOutL;
      default: return serOutW;
    endcase
  endfunction

  function automatic logic curValid();
    case (sel)
      0:       return serValidM;
      1:       return serValidL;
      default: return serValidW;
    endcase
  endfunction

  function automatic logic curReady();
    case (sel)
      0:       return ifM.in_ready;
      1:       return ifL.in_ready;
      default: return ifW.in_ready;
    endcase
  endfunction

  function automatic logic curBusy();
    case (sel)
      0:       return busyM;
      1:       return busyL;
      default: return busyW;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    case (sel)
      0: begin ifM.in_valid = valid; ifM.in_data = data; end
      1: begin ifL.in_valid = valid; ifL.in_data = data; end
      default: begin ifW.in_valid = valid; ifW.in_data = data[1:0]; end
    endcase
  endtask

  task automatic checkIdle(input string name);
    checkOutput($sformatf("%s ser_valid", name), curValid(), 1'b0);
    checkOutput($sformatf("%s ser_out", name), curOut(), SER_IDLE_LEVEL);
    checkOutput($sformatf("%s in_ready", name), curReady(), 1'b1);
    checkOutput($sformatf("%s busy", name), curBusy(), 1'b0);
  endtask

  // Called at the falling edge just after the accept edge; returns at the
  // falling edge after the frame's last bit.
  task automatic expectFrame(input logic [7:0] expStream, input logic expParity,
                             input int nBits, input bit stall, input string name);
    int   frameLen;
    logic expBit;
    frameLen = nBits + PAR_BITS;
    for (int i = 0; i < frameLen; i++) begin
      expBit = (i < nBits) ? expStream[nBits-1-i] : expParity;
      if (stall) applyStimulus((i >= 2) && (i <= 6), 8'hFF);
      checkOutput($sformatf("%s bit%0d ser_valid", name, i), curValid(), 1'b1);
      checkOutput($sformatf("%s bit%0d ser_out", name, i), curOut(), expBit);
      checkOutput($sformatf("%s bit%0d in_ready", name, i), curReady(), (i == frameLen - 1));
      checkOutput($sformatf("%s bit%0d busy", name, i), curBusy(), 1'b1);
      @(negedge clk);
    end
  endtask

  // Safety net so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, then multi-cycle corner cases.
  initial begin
    vecs[0] = '{0, 8'h92, 8'b1001_0010, 1'b1, 8, 1'b0, "msb_92"};
    vecs[1] = '{0, 8'hA5, 8'b1010_0101, 1'b0, 8, 1'b0, "msb_A5"};
    vecs[2] = '{0, 8'h80, 8'b1000_0000, 1'b1, 8, 1'b0, "msb_80"};
    vecs[3] = '{1, 8'h01, 8'b1000_0000, 1'b1, 8, 1'b1, "lsb_01_stall"};
    vecs[4] = '{1, 8'h92, 8'b0100_1001, 1'b1, 8, 1'b0, "lsb_92"};
    vecs[5] = '{1, 8'hC3, 8'b1100_0011, 1'b0, 8, 1'b0, "lsb_C3"};
    vecs[6] = '{2, 8'h02, 8'b0000_0010, 1'b1, 2, 1'b0, "w2_10"};
    vecs[7] = '{2, 8'h01, 8'b0000_0001, 1'b1, 2, 1'b0, "w2_01"};

    reset_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      applyStimulus(1'b0, 8'h00);
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      checkIdle($sformatf("reset dut%0d", s));
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      applyStimulus(1'b1, vecs[v].data);
      @(negedge clk);
      applyStimulus(1'b0, 8'h00);
      expectFrame(vecs[v].expStream, vecs[v].expParity, vecs[v].nBits, vecs[v].stall, vecs[v].name);
      checkIdle($sformatf("%s after", vecs[v].name));
    end

    // Back-to-back 8-bit words with valid held high throughout.
    sel = 0;
    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    applyStimulus(1'b1, 8'h3C);
    expectFrame(8'b1010_0101, 1'b0, 8, 1'b0, "b2b_A5");
    applyStimulus(1'b0, 8'h00);
    expectFrame(8'b0011_1100, 1'b0, 8, 1'b0, "b2b_3C");
    checkIdle("b2b after");

    // Back-to-back 2-bit words at the minimum width.
    sel = 2;
    applyStimulus(1'b1, 8'h02);
    @(negedge clk);
    applyStimulus(1'b1, 8'h01);
    expectFrame(8'b0000_0010, 1'b1, 2, 1'b0, "w2b2b_10");
    applyStimulus(1'b0, 8'h00);
    expectFrame(8'b0000_0001, 1'b1, 2, 1'b0, "w2b2b_01");
    checkIdle("w2b2b after");

    // Reset in the middle of a frame, then a fresh word from position 0.
    sel = 0;
    applyStimulus(1'b1, 8'hFF);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("midrst bit%0d ser_out", i), curOut(), 1'b1);
      @(negedge clk);
    end
    checkOutput("midrst bit4 ser_valid", curValid(), 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkIdle("midrst idle");
    applyStimulus(1'b1, 8'h5A);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    expectFrame(8'b0101_1010, 1'b0, 8, 1'b0, "after_rst_5A");
    checkIdle("after_rst after");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
